// File: rtl/fpdiv_post.sv
`default_nettype none
// ============================================================================
//  Module   : fpdiv_post
//  Purpose  : Single-precision divider completion stage: numerator x reciprocal,
//             normalise, round, IEEE special cases, in-flight counter.
//  Revision : 1.0
// ============================================================================
module fpdiv_post #(
   parameter int RLAT = 6
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   input  logic [31:0] numer_i,
   input  logic [31:0] denom_i,
   input  logic [31:0] recip_i,
   output logic        out_valid_o,
   output logic [31:0] quot_o,
   output logic        nv_o,
   output logic        dz_o,
   output logic [3:0]  inflight_o
);

   localparam int          DLW    = 37;
   localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      SP_NONE   = 3'd0,
      SP_NAN    = 3'd1,
      SP_INF_DZ = 3'd2,
      SP_INF    = 3'd3,
      SP_ZERO   = 3'd4
   } special_e;

   // Delay-line entry: {valid, numer, denom sign, denom zero/inf/nan}
   logic [DLW-1:0] dl_q [RLAT];
   logic [DLW-1:0] dl_d;

   always_comb begin : p_dl_in
      dl_d = {in_valid_i, numer_i, denom_i[31],
              denom_i[30:23] == 8'h00,
              (denom_i[30:23] == 8'hFF) && (denom_i[22:0] == 23'd0),
              (denom_i[30:23] == 8'hFF) && (denom_i[22:0] != 23'd0)};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin : p_dl
      if (!rst_ni) begin
         for (int k = 0; k < RLAT; k++) dl_q[k] <= '0;
      end else begin
         dl_q[0] <= dl_d;
         for (int k = 1; k < RLAT; k++) dl_q[k] <= dl_q[k-1];
      end
   end

   logic        t_valid, t_sd, t_dzero, t_dinf, t_dnan;
   logic [31:0] t_numer;
   assign {t_valid, t_numer, t_sd, t_dzero, t_dinf, t_dnan} = dl_q[RLAT-1];

   logic              n_zero, n_inf, n_nan;
   logic [47:0]       p_d, p_q;
   logic signed [9:0] e_d, e_q;
   special_e          spec_d, spec_q;
   logic              m_valid_q, s_q;

   always_comb begin : p_stage_m
      n_zero = t_numer[30:23] == 8'h00;
      n_inf  = (t_numer[30:23] == 8'hFF) && (t_numer[22:0] == 23'd0);
      n_nan  = (t_numer[30:23] == 8'hFF) && (t_numer[22:0] != 23'd0);
      p_d    = 48'({1'b1, t_numer[22:0]}) * 48'({1'b1, recip_i[22:0]});
      e_d    = 10'(t_numer[30:23]) + 10'(recip_i[30:23]) - 10'd127;
      spec_d = SP_NONE;
      if (n_nan || t_dnan)                             spec_d = SP_NAN;
      else if ((n_zero && t_dzero) || (n_inf && t_dinf)) spec_d = SP_NAN;
      else if (t_dzero)                                spec_d = n_inf ? SP_INF : SP_INF_DZ;
      else if (n_inf)                                  spec_d = SP_INF;
      else if (t_dinf || n_zero)                       spec_d = SP_ZERO;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin : p_m_reg
      if (!rst_ni) begin
         m_valid_q <= 1'b0;
         p_q       <= '0;
         e_q       <= '0;
         s_q       <= 1'b0;
         spec_q    <= SP_NONE;
      end else begin
         m_valid_q <= t_valid;
         p_q       <= p_d;
         e_q       <= e_d;
         s_q       <= t_numer[31] ^ t_sd;
         spec_q    <= spec_d;
      end
   end

   logic [22:0]       n_mant;
   logic              n_rb;
   logic [23:0]       n_rnd;
   logic signed [9:0] n_e1, n_e2;
   logic [31:0]       quot_d, quot_q;
   logic              nv_d, nv_q, dz_d, dz_q, out_valid_q;
   logic [3:0]        inflight_d, inflight_q;

   always_comb begin : p_stage_n
      if (p_q[47]) begin
         n_mant = p_q[46:24];
         n_rb   = p_q[23];
         n_e1   = e_q + 10'sd1;
      end else begin
         n_mant = p_q[45:23];
         n_rb   = p_q[22];
         n_e1   = e_q;
      end
      // A rounding carry leaves n_rnd[22:0] zero, i.e. mantissa 1.0
      n_rnd  = {1'b0, n_mant} + {23'd0, n_rb};
      n_e2   = n_rnd[23] ? n_e1 + 10'sd1 : n_e1;
      quot_d = '0;
      nv_d   = 1'b0;
      dz_d   = 1'b0;
      if (m_valid_q) begin
         unique case (spec_q)
            SP_NAN:    begin quot_d = C_QNAN; nv_d = 1'b1; end
            SP_INF_DZ: begin quot_d = {s_q, 8'hFF, 23'd0}; dz_d = 1'b1; end
            SP_INF:    quot_d = {s_q, 8'hFF, 23'd0};
            SP_ZERO:   quot_d = {s_q, 31'd0};
            default: begin
               if (n_e2 >= 10'sd255)    quot_d = {s_q, 8'hFF, 23'd0};
               else if (n_e2 <= 10'sd0) quot_d = {s_q, 31'd0};
               else                     quot_d = {s_q, n_e2[7:0], n_rnd[22:0]};
            end
         endcase
      end
   end

   always_comb begin : p_inflight
      inflight_d = inflight_q;
      case ({in_valid_i, out_valid_q})
         2'b10:   inflight_d = inflight_q + 4'd1;
         2'b01:   inflight_d = inflight_q - 4'd1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin : p_out_reg
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         quot_q      <= '0;
         nv_q        <= 1'b0;
         dz_q        <= 1'b0;
         inflight_q  <= '0;
      end else begin
         out_valid_q <= m_valid_q;
         quot_q      <= quot_d;
         nv_q        <= nv_d;
         dz_q        <= dz_d;
         inflight_q  <= inflight_d;
      end
   end

   // Reciprocal sign and sub-round product bits carry no information here
   logic unused_bits;
   assign unused_bits = ^{recip_i[31], p_q[21:0]};

   assign out_valid_o = out_valid_q;
   assign quot_o      = quot_q;
   assign nv_o        = nv_q;
   assign dz_o        = dz_q;
   assign inflight_o  = inflight_q;

endmodule
`default_nettype wire

// File: tb/tb_fpdiv_post.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpdiv_post
//  Purpose  : Self-checking bench for fpdiv_post with a behavioural model.
//  Revision : 1.0
// ============================================================================
module tb_fpdiv_post;

   localparam int RLAT = 6;
   localparam int N    = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] numer, denom, recip;
   logic        out_valid, nv, dz;
   logic [31:0] quot;
   logic [3:0]  inflight;

   always #5 clk = ~clk;

   fpdiv_post #(.RLAT(RLAT)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .numer_i     (numer),
      .denom_i     (denom),
      .recip_i     (recip),
      .out_valid_o (out_valid),
      .quot_o      (quot),
      .nv_o        (nv),
      .dz_o        (dz),
      .inflight_o  (inflight)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          mdl_infl = 0;
   bit          rv  [N];
   logic [31:0] sr  [N];
   bit          ev  [N];
   logic [31:0] eq  [N];
   bit          env [N];
   bit          edz [N];

   // 0 zero (incl. denormal), 1 finite nonzero, 2 inf, 3 nan
   function automatic int fcls(input logic [31:0] x);
      if (x[30:23] == 8'h00) return 0;
      if (x[30:23] != 8'hFF) return 1;
      return (x[22:0] == 23'd0) ? 2 : 3;
   endfunction

   function automatic logic [31:0] recip_model(input logic [31:0] d);
      logic [63:0] db, rb;
      int          e;
      real         x;
      db = {d[31], 11'(int'(d[30:23]) + 896), d[22:0], 29'd0};
      x  = 1.0 / $bitstoreal(db);
      rb = $realtobits(x);
      e  = int'(rb[62:52]) - 896;
      return {rb[63], e[7:0], rb[51:29]};
   endfunction

   function automatic void div_model(input logic [31:0] n, input logic [31:0] d,
                                     input logic [31:0] r, output logic [31:0] q,
                                     output bit f_nv, output bit f_dz);
      int cn, cd, e;
      bit s;
      longint unsigned p, m;
      cn = fcls(n);
      cd = fcls(d);
      s  = n[31] ^ d[31];
      f_nv = 1'b0;
      f_dz = 1'b0;
      if (cn == 3 || cd == 3 || (cn == 0 && cd == 0) || (cn == 2 && cd == 2)) begin
         q = 32'h7FC00000; f_nv = 1'b1;
      end else if (cd == 0) begin
         q = {s, 8'hFF, 23'd0}; f_dz = (cn == 1);
      end else if (cn == 2) begin
         q = {s, 8'hFF, 23'd0};
      end else if (cd == 2 || cn == 0) begin
         q = {s, 31'd0};
      end else begin
         p = longint'({1'b1, n[22:0]}) * longint'({1'b1, r[22:0]});
         e = int'(n[30:23]) + int'(r[30:23]) - 127;
         if (p >= (64'd1 << 47)) begin
            m = (p >> 24) + ((p >> 23) & 64'd1);
            e = e + 1;
         end else begin
            m = (p >> 23) + ((p >> 22) & 64'd1);
         end
         if (m >= (64'd1 << 24)) begin
            m = m >> 1;
            e = e + 1;
         end
         if (e >= 255)    q = {s, 8'hFF, 23'd0};
         else if (e <= 0) q = {s, 31'd0};
         else             q = {s, e[7:0], m[22:0]};
      end
   endfunction

   function automatic logic [31:0] rnd_fin(input int elo, input int ehi);
      return {1'($urandom), 8'($urandom_range(ehi, elo)), 23'($urandom)};
   endfunction

   function automatic logic [31:0] pick_spec();
      logic [31:0] t [7];
      t = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
            32'h7FC00000, 32'hFF800001, 32'h00400000};
      return t[$urandom_range(6, 0)];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", 32'(out_valid), 32'(ev[cyc]));
      chk("inflight", 32'(inflight), 32'(mdl_infl));
      if (ev[cyc]) begin
         chk("quot", quot, eq[cyc]);
         chk("nv", 32'(nv), 32'(env[cyc]));
         chk("dz", 32'(dz), 32'(edz[cyc]));
      end else begin
         chk("nv_idle", 32'(nv), 32'd0);
         chk("dz_idle", 32'(dz), 32'd0);
      end
   endtask

   task automatic step(input bit v, input logic [31:0] n, input logic [31:0] d,
                       input logic [31:0] r, input logic [31:0] q,
                       input bit xnv, input bit xdz);
      @(negedge clk);
      in_valid = v;
      numer    = n;
      denom    = d;
      recip    = rv[cyc] ? sr[cyc] : $urandom();
      if (v) begin
         rv[cyc+RLAT]    = 1'b1;
         sr[cyc+RLAT]    = r;
         ev[cyc+RLAT+2]  = 1'b1;
         eq[cyc+RLAT+2]  = q;
         env[cyc+RLAT+2] = xnv;
         edz[cyc+RLAT+2] = xdz;
      end
      mdl_infl = mdl_infl + int'(v) - int'(ev[cyc]);
      @(posedge clk);
      cyc++;
      #1;
      check_outputs();
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic issue_m(input logic [31:0] n, input logic [31:0] d);
      logic [31:0] r, q;
      bit          f_nv, f_dz;
      r = (fcls(d) == 1) ? recip_model(d) : $urandom();
      div_model(n, d, r, q, f_nv, f_dz);
      step(1'b1, n, d, r, q, f_nv, f_dz);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      numer    = '0;
      denom    = '0;
      recip    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_quot", quot, 32'd0);
      chk("rst_nv", 32'(nv), 32'd0);
      chk("rst_dz", 32'(dz), 32'd0);
      chk("rst_inflight", 32'(inflight), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases with hand-derived results, issued back to back
      step(1'b1, 32'h40C00000, 32'h40400000, 32'h3EAAAAAB, 32'h40000000, 1'b0, 1'b0);
      step(1'b1, 32'h3F800000, 32'h00000000, $urandom(),   32'h7F800000, 1'b0, 1'b1);
      step(1'b1, 32'h00000000, 32'h00000000, $urandom(),   32'h7FC00000, 1'b1, 1'b0);
      step(1'b1, 32'h7FC00001, 32'h3F800000, $urandom(),   32'h7FC00000, 1'b1, 1'b0);
      step(1'b1, 32'hC0000000, 32'h7F800000, $urandom(),   32'h80000000, 1'b0, 1'b0);
      step(1'b1, 32'h7F000000, 32'h3E800000, 32'h40800000, 32'h7F800000, 1'b0, 1'b0);
      step(1'b1, 32'h00800000, 32'h40000000, 32'h3F000000, 32'h00000000, 1'b0, 1'b0);
      step(1'b1, 32'hBF800000, 32'h40400000, 32'h3EAAAAAB, 32'hBEAAAAAB, 1'b0, 1'b0);
      step(1'b1, 32'h7F800000, 32'hFF800000, $urandom(),   32'h7FC00000, 1'b1, 1'b0);
      step(1'b1, 32'hFF800000, 32'h40000000, $urandom(),   32'hFF800000, 1'b0, 1'b0);
      step(1'b1, 32'h7F800000, 32'h00000000, $urandom(),   32'h7F800000, 1'b0, 1'b0);
      step(1'b1, 32'h80000000, 32'h40000000, $urandom(),   32'h80000000, 1'b0, 1'b0);
      step(1'b1, 32'h3FA1E58F, 32'h3F222222, 32'h3FCA6691, 32'h40000000, 1'b0, 1'b0);
      idle(RLAT + 3);

      // Ten back-to-back issues; inflight must climb to RLAT+2 and drain
      for (int i = 0; i < 10; i++) issue_m(rnd_fin(100, 154), rnd_fin(64, 190));
      idle(RLAT + 3);

      // Random mix with gaps, specials, overflow and underflow
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(3, 0) != 0)
            issue_m(($urandom_range(7, 0) == 0) ? pick_spec() : rnd_fin(1, 254),
                    ($urandom_range(7, 0) == 0) ? pick_spec() : rnd_fin(64, 190));
         else
            idle(1);
      end
      idle(RLAT + 3);

      // Asynchronous reset with three operations in flight
      for (int i = 0; i < 3; i++) issue_m(rnd_fin(100, 154), rnd_fin(64, 190));
      idle(2);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_inflight", 32'(inflight), 32'd0);
      for (int i = 0; i < N; i++) begin
         rv[i] = 1'b0;
         ev[i] = 1'b0;
      end
      mdl_infl = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         numer    = rnd_fin(100, 154);
         denom    = rnd_fin(64, 190);
         @(posedge clk);
         cyc++;
         #1;
         chk("inrst_out_valid", 32'(out_valid), 32'd0);
         chk("inrst_inflight", 32'(inflight), 32'd0);
      end
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      check_outputs();
      idle(RLAT + 3);
      issue_m(32'h40C00000, 32'h40400000);
      idle(RLAT + 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fpdiv_post.md
# fpdiv_post

Downstream completion stage of the single-precision divider. It accepts a numerator/denominator pair at issue time and delays the numerator through an internal pipeline. The reciprocal pipeline produces 1/denominator exactly RLAT cycles after issue; this block captures that reciprocal on arrival, multiplies it by the numerator, then normalises, rounds and applies IEEE special-case rules. It also counts operations in flight for the issuing sequencer.

## Interface
- RLAT, 6, cycles from `in_valid`/`denom` presented to matching `recip` valid on input; legal range 1..13
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  issue strobe, one operation per cycle, no backpressure
- numer  in  32  dividend, IEEE single, sampled with `in_valid`
- denom  in  32  divisor, IEEE single, sampled with `in_valid`
- recip  in  32  reciprocal of the `denom` issued RLAT cycles earlier; don't-care otherwise
- out_valid  out  1  result strobe, one cycle per operation
- quot  out  32  quotient, IEEE single
- nv  out  1  invalid-operation flag, qualified by `out_valid`
- dz  out  1  divide-by-zero flag, qualified by `out_valid`
- inflight  out  4  operations issued but not yet retired

## Operation
- Delay line D1..DRLAT: shifts valid, numer, sign(denom) and denom class (zero, inf, nan). Denom mantissa is not stored.
- Classification: exp==0 is zero, so denormals are flushed. exp==255 with mant==0 is inf. exp==255 with mant!=0 is NaN.
- Stage M, on the cycle after DRLAT: captures `recip`.
  - P = {1,Mn}*{1,Mr}, 48 bits.
  - E = En + Er - 127, 10-bit signed.
  - s = sn ^ sd.
  - Special code from the class bits.
- Stage N normalisation:
  - If P[47]: mantissa = P[46:24], round bit P[23], E+1.
  - Else: mantissa = P[45:23], round bit P[22].
- Stage N rounding: round-half-up on magnitude, i.e. add the round bit. A carry out renormalises to 1.0 and adds 1 to E.
- Range, checked after rounding:
  - E>=255 gives {s,7F800000[30:0]} (signed inf).
  - E<=0 gives {s,31'b0} (signed zero, flush).
- Special cases, highest priority first; they override the arithmetic path, and `recip` is ignored for them:
  - NaN on either input: 7FC00000, nv=1.
  - 0/0 or inf/inf: 7FC00000, nv=1.
  - Finite nonzero / 0: signed inf, dz=1.
  - inf / finite: signed inf.
  - Finite / inf: signed zero.
  - 0 / nonzero finite: signed zero.
- inflight:
  - +1 on `in_valid` alone.
  - -1 on `out_valid` alone.
  - Unchanged when both occur in the same cycle.
  - Never wraps within the legal RLAT range.

## Timing
- Latency: `in_valid` at cycle t produces `out_valid`/`quot` at cycle t+RLAT+2.
- Throughput is 1 per cycle. Results are in issue order and no bubbles are inserted.
- The `recip` sample point is exactly cycle t+RLAT. No other alignment is supported.
- Reset values, applied asynchronously while `rst` is low: `out_valid`=0, `quot`=0, `nv`=0, `dz`=0, `inflight`=0, all delay-line valid bits 0.
- Reset mid-operation: all in-flight operations are discarded. No `out_valid` appears for any operation issued before `rst` deasserted. `in_valid` is ignored while `rst` is low.
- Outputs are registered, with no combinational path from inputs.
- `nv` and `dz` are 0 whenever `out_valid` is 0.
- Maximum `inflight` is RLAT+2.

## Test plan
- **Basic divide:** numer=40C00000 (6.0), denom=40400000, recip=3EAAAAAB at t+6 -> quot=40000000, out_valid at t+8, nv=dz=0.
- **Specials:**
  - 3F800000/00000000 -> 7F800000 with dz=1.
  - 00000000/00000000 -> 7FC00000 with nv=1.
  - 7FC00001/any -> 7FC00000 with nv=1.
  - C0000000/7F800000 -> 80000000.
- **Overflow and underflow:**
  - 7F000000/3E800000, recip=40800000 -> 7F800000, dz=0.
  - 00800000/40000000, recip=3F000000 -> 00000000.
- **Sign and rounding:** BF800000/40400000, recip=3EAAAAAB -> BEAAAAAB.
- **Throughput:** 10 back-to-back issues with distinct operands and a reference model for `recip`.
  - inflight climbs to 8 and holds at 8.
  - 10 results appear in order on consecutive cycles.
  - inflight returns to 0 two cycles... precisely at the cycle after the last `out_valid`.
- **Reset mid-stream:** assert `rst` with 3 operations in flight -> `out_valid`=0 and `inflight`=0 immediately (asynchronous). After release, no stale results appear, and a new issue completes in RLAT+2 cycles.
